mprj_io_cfg_loader: RTL and testbench

- Sequencer that programs the per-pad configuration held in the user-project GPIO control blocks that drive the mprj_io pad array (oeb, inp_dis, dm, slow_sel, etc.).
- Fetches one CFG_BITS-wide config word per pad from the housekeeping config register file.
- Shifts the words MSB-first over two serial chains, one for pad area 1 and one for pad area 2, then pulses a shared load strobe so every pad's shadow register updates at once.
- Sits between housekeeping and the GPIO control blocks. Triggered by a one-cycle start pulse.

---
 rtl/mprj_io_cfg_pkg.sv | 29 ++
 rtl/mprj_io_cfg_shifter.sv | 67 ++++++
 rtl/mprj_io_cfg_loader.sv | 131 +++++++++++++
 tb/tb_mprj_io_cfg_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_io_cfg_pkg.sv
// Shared definitions for the mprj_io pad configuration loader: word width,
// GPIO control-block field offsets and the loader state encoding.
package mprj_io_cfg_pkg;

  localparam int CFG_BITS = 13;

  // Bit offsets of the fields inside one pad configuration word
  localparam int MGMT_EN     = 0;
  localparam int OUT_DIS     = 1;
  localparam int HOLDOVER    = 2;
  localparam int INP_DIS     = 3;
  localparam int IB_MODE_SEL = 4;
  localparam int ANALOG_EN   = 5;
  localparam int ANALOG_SEL  = 6;
  localparam int ANALOG_POL  = 7;
  localparam int SLOW_SEL    = 8;
  localparam int VTRIP_SEL   = 9;
  localparam int DM          = 10;
  localparam int DM_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LOAD     = 3'd3,
    ST_DONE     = 3'd4
  } loader_state_e;

endpackage

// File: rtl/mprj_io_cfg_shifter.sv
// One serial configuration chain: walks its pads word by word, MSB first,
// and emits leading zeros when it is shorter than the longest chain.
module mprj_io_cfg_shifter
  import mprj_io_cfg_pkg::*;
#(
  parameter int LEN   = 19,
  parameter int LMAX  = 19,
  parameter int FIRST = 18,
  parameter int UP    = 0,
  parameter int IDXW  = 6
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                adv_i,
  input  logic                clr_i,
  input  logic [CFG_BITS-1:0] cfg_word_i,
  output logic [IDXW-1:0]     cfg_idx_o,
  output logic                data_o
);

  localparam int PADW = LMAX - LEN;
  localparam int WW   = $clog2(LMAX + 1);
  localparam int BW   = $clog2(CFG_BITS + 1);

  // word_q/bit_q name the next bit to be emitted; they wrap to zero after the
  // last bit so the index returns to the first pad without going out of range.
  logic [WW-1:0]       word_q;
  logic [BW-1:0]       bit_q;
  logic                data_q;
  logic                real_word;
  int                  offset;
  int                  pad;
  logic [CFG_BITS-1:0] shifted;

  always_comb begin
    real_word = (LEN > 0) && (int'(word_q) >= PADW);
    offset    = real_word ? (int'(word_q) - PADW) : 0;
    if (LEN == 0)     pad = 0;
    else if (UP != 0) pad = FIRST + offset;
    else              pad = FIRST - offset;
    cfg_idx_o = IDXW'(pad);
    shifted   = cfg_word_i << bit_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      word_q <= '0;
      bit_q  <= '0;
      data_q <= 1'b0;
    end else if (clr_i) begin
      word_q <= '0;
      bit_q  <= '0;
      data_q <= 1'b0;
    end else if (adv_i) begin
      data_q <= real_word ? shifted[CFG_BITS-1] : 1'b0;
      if (bit_q == BW'(CFG_BITS - 1)) begin
        bit_q  <= '0;
        word_q <= (word_q == WW'(LMAX - 1)) ? '0 : word_q + 1'b1;
      end else begin
        bit_q <= bit_q + 1'b1;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Sequencer that reloads every mprj_io pad configuration over two serial
// chains and then strobes a shared parallel load.
module mprj_io_cfg_loader
  import mprj_io_cfg_pkg::*;
#(
  parameter int AREA1PADS  = 19,
  parameter int TOTAL_PADS = 38,
  parameter int CLK_DIV    = 2
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          xfer_start,
  output logic [$clog2(TOTAL_PADS)-1:0] cfg_idx1,
  input  logic [CFG_BITS-1:0]           cfg_word1,
  output logic [$clog2(TOTAL_PADS)-1:0] cfg_idx2,
  input  logic [CFG_BITS-1:0]           cfg_word2,
  output logic                          serial_clock,
  output logic                          serial_data_1,
  output logic                          serial_data_2,
  output logic                          serial_load,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    dbg_state
);

  localparam int IDXW  = $clog2(TOTAL_PADS);
  localparam int L1    = AREA1PADS;
  localparam int L2    = TOTAL_PADS - AREA1PADS;
  localparam int LMAX  = (L1 > L2) ? L1 : L2;
  localparam int NBITS = LMAX * CFG_BITS;
  localparam int CW    = $clog2(NBITS + 1);
  localparam int DW    = $clog2(2 * CLK_DIV + 1);

  loader_state_e state_q;
  logic [DW-1:0] div_q;
  logic [CW-1:0] bit_q;
  logic          sclk_q, load_q, busy_q, done_q;
  logic          half_end, load_end, last_bit, adv, clr;

  assign half_end = (div_q == DW'(CLK_DIV - 1));
  assign load_end = (div_q == DW'(2 * CLK_DIV - 1));
  assign last_bit = (bit_q == CW'(NBITS - 1));
  // Chains emit a new bit exactly when SHIFT_LO is entered; they clear on LOAD.
  assign adv = ((state_q == ST_IDLE) && xfer_start) ||
               ((state_q == ST_SHIFT_HI) && half_end && !last_bit);
  assign clr = (state_q == ST_SHIFT_HI) && half_end && last_bit;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer_start) begin
            state_q <= ST_SHIFT_LO;
            busy_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
          end
        end
        ST_SHIFT_LO: begin
          if (half_end) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= ST_SHIFT_HI;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (half_end) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            if (last_bit) begin
              state_q <= ST_LOAD;
              load_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT_LO;
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_end) begin
            div_q   <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mprj_io_cfg_shifter #(
    .LEN(L1), .LMAX(LMAX), .FIRST(AREA1PADS - 1), .UP(0), .IDXW(IDXW)
  ) u_chain1 (
    .clock(clock), .resetn(resetn), .adv_i(adv), .clr_i(clr),
    .cfg_word_i(cfg_word1), .cfg_idx_o(cfg_idx1), .data_o(serial_data_1)
  );

  mprj_io_cfg_shifter #(
    .LEN(L2), .LMAX(LMAX), .FIRST(AREA1PADS), .UP(1), .IDXW(IDXW)
  ) u_chain2 (
    .clock(clock), .resetn(resetn), .adv_i(adv), .clr_i(clr),
    .cfg_word_i(cfg_word2), .cfg_idx_o(cfg_idx2), .data_o(serial_data_2)
  );

  assign serial_clock = sclk_q;
  assign serial_load  = load_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Bench for mprj_io_cfg_loader with asymmetric chains (10 + 28 pads) and a
// 3-cycle serial half-period; outputs are predicted from elapsed transfer time.
module tb_mprj_io_cfg_loader;
  import mprj_io_cfg_pkg::*;

  localparam int A1    = 10;
  localparam int TOT   = 38;
  localparam int CD    = 3;
  localparam int CB    = CFG_BITS;
  localparam int L1    = A1;
  localparam int L2    = TOT - A1;
  localparam int LMAX  = (L1 > L2) ? L1 : L2;
  localparam int NBITS = LMAX * CB;
  localparam int TLOAD = 2 * CD * NBITS;
  localparam int TDONE = 2 * CD * (NBITS + 1);
  localparam int IDXW  = $clog2(TOT);

  // ---------------- clock / reset / DUT ----------------
  logic clock = 1'b0;
  logic resetn, xfer_start;
  logic [IDXW-1:0] cfg_idx1, cfg_idx2;
  logic [CB-1:0]   cfg_word1, cfg_word2;
  logic serial_clock, serial_data_1, serial_data_2, serial_load, busy, done;
  logic [2:0] dbg_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [CB-1:0] cfg_mem [TOT];
  logic [CB-1:0] old_cfg [TOT];
  logic [CB-1:0] shadow  [TOT];

  assign cfg_word1 = cfg_mem[cfg_idx1];
  assign cfg_word2 = cfg_mem[cfg_idx2];

  mprj_io_cfg_loader #(
    .AREA1PADS(A1), .TOTAL_PADS(TOT), .CLK_DIV(CD)
  ) dut (
    .clock(clock), .resetn(resetn), .xfer_start(xfer_start),
    .cfg_idx1(cfg_idx1), .cfg_word1(cfg_word1),
    .cfg_idx2(cfg_idx2), .cfg_word2(cfg_word2),
    .serial_clock(serial_clock), .serial_data_1(serial_data_1),
    .serial_data_2(serial_data_2), .serial_load(serial_load),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Bit k of the stream for a chain: leading zeros for the shorter chain,
  // then pad words in chain order, each MSB first.
  function automatic logic exp_bit(input int chain, input int k);
    int w, b, pad, padw;
    w = k / CB;
    b = k % CB;
    padw = (chain == 1) ? (LMAX - L1) : (LMAX - L2);
    if (w < padw) return 1'b0;
    pad = (chain == 1) ? (A1 - 1 - (w - padw)) : (A1 + (w - padw));
    return cfg_mem[pad][CB-1-b];
  endfunction

  // {busy, done, load, sclk, data1, data2} for transfer time t (-1 = idle)
  function automatic logic [5:0] exp_out(input int t);
    int  k;
    logic s;
    if (t < 0) return 6'b000000;
    if (t < TLOAD) begin
      k = t / (2 * CD);
      s = ((t % (2 * CD)) >= CD);
      return {1'b1, 1'b0, 1'b0, s, exp_bit(1, k), exp_bit(2, k)};
    end
    if (t < TDONE) return 6'b101000;
    return 6'b010000;
  endfunction

  int   m_t = -1;
  int   e0 = 0;
  int   rises = 0, ones1 = 0, ones2 = 0, first1 = -1;
  logic prev_sclk = 1'b0, prev_load = 1'b0;
  logic [L1*CB-1:0] sr1 = '0;
  logic [L2*CB-1:0] sr2 = '0;
  bit   ones_mode = 1'b0;

  always @(negedge clock) begin
    if (!resetn) begin
      m_t = -1; rises = 0; ones1 = 0; ones2 = 0; first1 = -1;
      prev_sclk = 1'b0; prev_load = 1'b0;
    end else begin
      chk("outputs", {busy, done, serial_load, serial_clock, serial_data_1, serial_data_2},
          exp_out(m_t));
      chk("idx_range", {cfg_idx1 < TOT, cfg_idx2 < TOT}, 2'b11);
      if (m_t < 0) chk("idle_idx", {cfg_idx1, cfg_idx2}, {6'(A1 - 1), 6'(A1)});
      // Pad chain model: shift on each rising serial_clock, latch on load.
      if (serial_clock && !prev_sclk) begin
        if (serial_data_1) begin
          ones1++;
          if (first1 < 0) first1 = rises;
        end
        if (serial_data_2) ones2++;
        sr1 = {sr1[L1*CB-2:0], serial_data_1};
        sr2 = {sr2[L2*CB-2:0], serial_data_2};
        rises++;
      end
      if (serial_load && !prev_load) begin
        for (int p = 0; p < TOT; p++)
          shadow[p] = (p < A1) ? sr1[p*CB +: CB] : sr2[(TOT-1-p)*CB +: CB];
      end
      if (done) begin
        chk("done_latency", cyc - e0, 2190);     // 2*3*(28*13+1)
        chk("sclk_rises", rises, 364);           // 28*13
        if (ones_mode) begin
          chk("ones_chain1", ones1, 130);        // 10 pads * 13
          chk("ones_chain2", ones2, 364);
          chk("first_one_chain1", first1, 234);  // 18 padding words * 13
        end
        for (int p = 0; p < TOT; p++)
          chk($sformatf("pad%0d_cfg", p), shadow[p], cfg_mem[p]);
        rises = 0; ones1 = 0; ones2 = 0; first1 = -1;
      end
      prev_sclk = serial_clock;
      prev_load = serial_load;
      // Advance the model: xfer_start now is what the next edge samples.
      if (m_t < 0) begin
        if (xfer_start) begin
          m_t = 0;
          e0  = cyc + 1;
        end
      end else if (m_t == TDONE) begin
        m_t = -1;
      end else begin
        m_t++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_at(input int e);
    while (cyc < e - 1) step();
    #1 xfer_start = 1'b1;
    step();
    xfer_start = 1'b0;
  endtask

  task automatic fill_random();
    for (int p = 0; p < TOT; p++) cfg_mem[p] = CB'($urandom_range(0, (1 << CB) - 1));
  endtask

  task automatic fill_const(input logic [CB-1:0] v);
    for (int p = 0; p < TOT; p++) cfg_mem[p] = v;
  endtask

  task automatic run_one();
    int s;
    s = cyc + 2;
    pulse_at(s);
    repeat (TDONE + 10) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    resetn = 1'b0;
    xfer_start = 1'b0;
    fill_random();
    for (int p = 0; p < TOT; p++) shadow[p] = '0;
    repeat (3) step();
    chk("reset_outputs", {busy, done, serial_load, serial_clock, serial_data_1, serial_data_2}, 6'b0);
    chk("reset_idx", {cfg_idx1, cfg_idx2}, {6'd9, 6'd10});
    chk("reset_state", dbg_state, ST_IDLE);
    resetn = 1'b1;
    repeat (4) step();

    // Starts during the transfer and on its DONE cycle must be dropped.
    s = cyc + 2;
    pulse_at(s);
    pulse_at(s + 5);
    pulse_at(s + 500);
    pulse_at(s + TDONE + 1);
    repeat (30) step();
    chk("no_queued_start", busy, 1'b0);

    run_one();                 // same words again
    fill_const('1);
    ones_mode = 1'b1;
    run_one();
    ones_mode = 1'b0;
    fill_const('0);
    run_one();

    // Held request re-triggers only once the loader is back in IDLE.
    fill_random();
    xfer_start = 1'b1;
    repeat (TDONE + 20) step();
    xfer_start = 1'b0;
    repeat (TDONE + 10) step();
    chk("idle_after_hold", busy, 1'b0);

    // Abort mid SHIFT_HI: pads must keep the previous configuration.
    for (int p = 0; p < TOT; p++) old_cfg[p] = cfg_mem[p];
    fill_random();
    s = cyc + 2;
    pulse_at(s);
    while (cyc < s + 46) step();
    chk("mid_shift_hi", dbg_state, ST_SHIFT_HI);
    #1 resetn = 1'b0;
    #1;
    chk("async_reset_outputs",
        {busy, done, serial_load, serial_clock, serial_data_1, serial_data_2}, 6'b0);
    chk("async_reset_idx", {cfg_idx1, cfg_idx2}, {6'd9, 6'd10});
    repeat (3) step();
    resetn = 1'b1;
    repeat (20) step();
    for (int p = 0; p < TOT; p++) chk($sformatf("abort_pad%0d", p), shadow[p], old_cfg[p]);

    run_one();                 // recovery with the new words

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
